// File: rtl/i2c_line_receiver_pkg.sv
// Shared constants for the I2C line receiver: filter default, bit-counter
// terminal value and idle (reset) levels of the bus lines.
package i2c_line_receiver_pkg;

  localparam int         FILTER_LEN_DEF = 3;
  localparam int         CNT_W_DEF      = 4;
  localparam logic [3:0] BIT_CNT_ACK    = 4'd8;
  localparam logic       SCL_IDLE       = 1'b1;
  localparam logic       SDA_IDLE       = 1'b1;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser followed by a persistence filter: the output only
// follows the synchronised line after FILTER_LEN consecutive differing clocks.
module i2c_glitch_filter #(
  parameter int   FILTER_LEN = 3,
  parameter int   CNT_W      = 4,
  parameter logic RST_VAL    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic line_o
);

  localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(FILTER_LEN - 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    // The FILTER_LEN-th differing clock flips the output and restarts the count.
    if (sync2_q != filt_q) begin
      if (cnt_q == LEN_M1) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      filt_q  <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/i2c_line_receiver.sv
// I2C receive front end: filtered SCL/SDA, edge and START/STOP detection,
// and 8-bit + ACK deserialisation into single-cycle pulses.
module i2c_line_receiver
  import i2c_line_receiver_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       scl_rise_o,
  output logic       scl_fall_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic [7:0] data_o,
  output logic       byte_valid_o,
  output logic       ack_o,
  output logic       ack_valid_o,
  output logic       frame_err_o
);

  logic scl_f, sda_f;

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W), .RST_VAL(SCL_IDLE)) u_scl_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .line_i(scl_i),
    .line_o(scl_f)
  );

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W), .RST_VAL(SDA_IDLE)) u_sda_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .line_i(sda_i),
    .line_o(sda_f)
  );

  logic       prev_scl_q, prev_sda_q;
  logic       rise_d, fall_d, start_d, stop_d;
  logic       rise_q, fall_q, start_q, stop_q;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       byte_vld_q, byte_vld_d;
  logic       ack_vld_q, ack_vld_d;
  logic       ferr_q, ferr_d;

  // START/STOP need SCL stable high, so a simultaneous SCL change masks them.
  always_comb begin
    rise_d  = ~prev_scl_q & scl_f;
    fall_d  = prev_scl_q & ~scl_f;
    start_d = prev_scl_q & scl_f & prev_sda_q & ~sda_f;
    stop_d  = prev_scl_q & scl_f & ~prev_sda_q & sda_f;
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    byte_vld_d = 1'b0;
    ack_vld_d  = 1'b0;
    ferr_d     = 1'b0;
    if (start_d || stop_d) begin
      bit_cnt_d = '0;
      ferr_d    = (bit_cnt_q != 4'd0);
      busy_d    = start_d;
    end else if (rise_d && busy_q) begin
      if (bit_cnt_q == BIT_CNT_ACK) begin
        ack_d     = ~sda_f;
        ack_vld_d = 1'b1;
        bit_cnt_d = '0;
      end else begin
        shreg_d   = {shreg_q[5:0], sda_f};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd7) begin
          data_d     = {shreg_q, sda_f};
          byte_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_scl_q <= SCL_IDLE;
      prev_sda_q <= SDA_IDLE;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      data_q     <= 8'h00;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      byte_vld_q <= 1'b0;
      ack_vld_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      prev_scl_q <= scl_f;
      prev_sda_q <= sda_f;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      byte_vld_q <= byte_vld_d;
      ack_vld_q  <= ack_vld_d;
      ferr_q     <= ferr_d;
    end
  end

  assign scl_o        = scl_f;
  assign sda_o        = sda_f;
  assign scl_rise_o   = rise_q;
  assign scl_fall_o   = fall_q;
  assign start_o      = start_q;
  assign stop_o       = stop_q;
  assign busy_o       = busy_q;
  assign data_o       = data_q;
  assign byte_valid_o = byte_vld_q;
  assign ack_o        = ack_q;
  assign ack_valid_o  = ack_vld_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: doc/i2c_line_receiver.md
Name: i2c_line_receiver

Overview:
- Front-end receive stage for the I2C BERT target; sits directly upstream of the negedge-sampled flop stages.
- Synchronises and glitch-filters raw SCL/SDA pins, then detects SCL edges and START/STOP conditions.
- Deserialises 8 data bits plus the ACK bit, delivering bytes and ACK status as single-cycle pulses to the protocol FSM.
- Everything runs on one system clock; SCL is treated as data, never as a clock.

Parameters:
- FILTER_LEN, 3: consecutive clocks a synchronised line must differ from its filtered value before the filtered value flips (legal 1..15).
- CNT_W, 4: width of each filter counter; must satisfy 2^CNT_W > FILTER_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- scl_i  input  1  raw SCL pin, asynchronous.
- sda_i  input  1  raw SDA pin, asynchronous.
- scl_o  output  1  filtered SCL level.
- sda_o  output  1  filtered SDA level.
- scl_rise_o  output  1  one-cycle pulse on filtered SCL 0->1.
- scl_fall_o  output  1  one-cycle pulse on filtered SCL 1->0.
- start_o  output  1  one-cycle pulse, START or repeated START.
- stop_o  output  1  one-cycle pulse, STOP.
- busy_o  output  1  high from START until STOP.
- data_o  output  8  last completed byte, MSB first; holds until the next byte completes.
- byte_valid_o  output  1  one-cycle pulse, data_o updated.
- ack_o  output  1  1 = ACK (SDA low on 9th SCL rise); holds.
- ack_valid_o  output  1  one-cycle pulse, ack_o updated.
- frame_err_o  output  1  one-cycle pulse, START/STOP seen with bit_cnt != 0.

Behaviour:
- Reset (async, rst_n=0):
  - sync flops, scl_o and sda_o = 1.
  - All pulses, busy_o and ack_o = 0; data_o = 8'h00.
  - bit_cnt = 0; filter counters = 0.
  - Reset asserted mid-byte discards the partial byte; no pulse is emitted.
- Synchroniser: two flops per line, reset value 1.
- Filter (per line):
  - If synced == filtered, the counter clears.
  - Otherwise the counter increments. When it reaches FILTER_LEN, filtered takes the synced value and the counter clears.
  - A pulse shorter than FILTER_LEN clocks never propagates.
  - Latency from pin change to scl_o/sda_o = 2 + FILTER_LEN clocks.
- Event detection: registered, comparing current filtered values with the previous cycle's filtered values (prev_*, reset value 1).
  - scl_rise/scl_fall are asserted 1 clock after scl_o changes.
  - start: prev_scl=1, scl=1, prev_sda=1, sda=0.
  - stop: prev_scl=1, scl=1, prev_sda=0, sda=1.
  - If SCL and SDA both change in the same cycle, only the SCL edge is reported; no START/STOP.
- Bit counter (0..8):
  - start_o or stop_o: bit_cnt <- 0. frame_err_o pulses in the same cycle if bit_cnt != 0.
  - start_o sets busy_o; stop_o clears it.
  - scl_rise while busy_o and bit_cnt < 8: shift sda into shreg LSB; bit_cnt++.
  - On the rise with bit_cnt = 7: data_o <- {shreg[6:0], sda} and byte_valid_o pulses on the following clock.
  - scl_rise with bit_cnt = 8: ack_o <- ~sda, ack_valid_o pulses, bit_cnt <- 0 (wrap).
  - scl_rise while !busy_o is ignored.
- Repeated START mid-byte: partial byte discarded, frame_err_o pulses, busy_o stays 1.
- At most one of byte_valid_o / ack_valid_o is asserted per cycle.
- start_o and stop_o are never asserted in the same cycle.

Decomposition:
- Shared header/package: FILTER_LEN default, BIT_CNT_ACK = 4'd8, reset-level constants (SCL/SDA idle = 1).
- One natural sub-module, i2c_glitch_filter (synchroniser + counter filter, parameters FILTER_LEN/CNT_W), instantiated once for SCL and once for SDA.

Test Plan:
- Reset with pins idle high, release rst_n -> scl_o=1, sda_o=1, data_o=8'h00, busy_o=0, no pulses for 50 clocks.
- FILTER_LEN=3: 2-clock low glitch on sda_i while scl_i=1 -> sda_o stays 1, no start_o; a 4-clock low pulse -> start_o exactly 6 clocks after the sda_i fall.
- START, bytes 8'hA5 then ACK (SDA low), STOP -> start_o, byte_valid_o with data_o=8'hA5, ack_valid_o with ack_o=1, stop_o, busy_o back to 0.
- START, byte 8'h3C with NACK (SDA high on 9th) -> data_o=8'h3C, ack_o=0.
- START, 4 bits of 1010, repeated START, byte 8'hFF -> frame_err_o once, no byte_valid_o for the partial byte, then data_o=8'hFF, busy_o held 1 throughout.
- SCL and SDA toggled in the same clock while SCL high -> scl_fall_o pulses, no start_o/stop_o; async rst_n pulse mid-byte -> all outputs at reset values immediately.
